// File: rtl/booth_mult_seq_if.sv
// Operand/result handshake bundle for booth_mult_seq.
//   in_valid/in_ready  : operand handshake (a, b, is_signed qualified by in_valid)
//   out_valid/out_ready: result handshake (result qualified by out_valid)
//   busy               : multiplier is not idle
// master = operand issuer / result consumer, slave = the multiplier.
interface booth_mult_seq_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, one Booth digit per clock.
// Signed or unsigned operands, valid/ready handshakes on both sides.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : booth_mult_seq_if.slave (operands in, product out, busy)
// Accept at edge k -> out_valid after edge k+WIDTH/2+1. result holds its
// last product until the next one is loaded.
module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    booth_mult_seq_if.slave    bus
);
    localparam int EW   = WIDTH + 2;        // extended operand width
    localparam int AW   = 2 * WIDTH + 4;    // accumulator width
    localparam int NDIG = WIDTH / 2 + 1;    // Booth digits per product
    localparam int CW   = $clog2(NDIG);
    localparam int LAST = WIDTH / 2;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("booth_mult_seq: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        mcand_q, mcand_d;   // A << 2i, sign-extended to AW
    logic [EW-1:0]        mplr_q, mplr_d;     // b_ext >> 2i
    logic                 prev_q, prev_d;     // b_ext[2i-1]
    logic [AW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [EW-1:0]        a_ext;
    logic [EW-1:0]        b_ext;
    logic [AW-1:0]        addend;
    logic [AW-1:0]        sum;
    logic                 in_ready;

    assign in_ready      = (state_q == IDLE) && !rst;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;

    assign a_ext = bus.is_signed ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
    assign b_ext = bus.is_signed ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};

    // Instead of shifting the addend by 2i, the multiplicand is pre-shifted
    // left and the multiplier shifted right by two bits every digit.
    always_comb begin
        addend = '0;
        unique case ({mplr_q[1:0], prev_q})
            3'b001, 3'b010: addend = mcand_q;
            3'b011:         addend = mcand_q << 1;
            3'b100:         addend = -(mcand_q << 1);
            3'b101, 3'b110: addend = -mcand_q;
            default:        addend = '0;
        endcase
    end

    assign sum = acc_q + addend;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        prev_d   = prev_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    mcand_d = {{(AW-EW){a_ext[EW-1]}}, a_ext};
                    mplr_d  = b_ext;
                    prev_d  = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = sum;
                mcand_d = mcand_q << 2;
                mplr_d  = mplr_q >> 2;
                prev_d  = mplr_q[1];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(LAST)) begin
                    result_d = sum[2*WIDTH-1:0];
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplr_q   <= '0;
            prev_q   <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            prev_q   <= prev_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_mult_seq_if #(.WIDTH(32)) if32();
    booth_mult_seq_if #(.WIDTH(8))  if8();

    booth_mult_seq #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    booth_mult_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

    int tests = 0;
    int fails = 0;

    logic [63:0] exp_q32[$];
    logic [15:0] exp_q8[$];

    logic rr_en32 = 1'b0, rr_en8 = 1'b0;
    logic rdy_dir32 = 1'b1, rdy_dir8 = 1'b1;
    logic rdy_rand32 = 1'b1, rdy_rand8 = 1'b1;
    bit   done32 = 1'b0, done8 = 1'b0, start8 = 1'b0;

    logic [7:0] corner8 [8] = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};

    assign if32.out_ready = rr_en32 ? rdy_rand32 : rdy_dir32;
    assign if8.out_ready  = rr_en8  ? rdy_rand8  : rdy_dir8;

    always @(posedge clk) begin
        #1;
        rdy_rand32 = ($urandom_range(0, 3) != 0);
        rdy_rand8  = ($urandom_range(0, 2) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference products from plain integer arithmetic.
    function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int sa, sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = int'(a);
            sb = int'(b);
        end
        return 16'(sa * sb);
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 9))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp);
        int n = 0;
        if32.a = a;
        if32.b = b;
        if32.is_signed = s;
        if32.in_valid = 1'b1;
        @(negedge clk);
        while (!if32.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!if32.in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout32: in_ready stayed 0 for %0d cycles, expected 1", n);
        end else begin
            exp_q32.push_back(exp);
        end
        @(posedge clk);
        #1;
        if32.in_valid = 1'b0;
        if32.a = $urandom;
        if32.b = $urandom;
        if32.is_signed = $urandom_range(0, 1);
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int n = 0;
        if8.a = a;
        if8.b = b;
        if8.is_signed = s;
        if8.in_valid = 1'b1;
        @(negedge clk);
        while (!if8.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!if8.in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout8: in_ready stayed 0 for %0d cycles, expected 1", n);
        end else begin
            exp_q8.push_back(model8(a, b, s));
        end
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        if8.a = 8'($urandom);
        if8.b = 8'($urandom);
        if8.is_signed = $urandom_range(0, 1);
    endtask

    task automatic wait_valid32(output int j);
        j = 0;
        while (!if32.out_valid && j < 60) begin
            @(posedge clk);
            #1;
            j++;
        end
    endtask

    // Scoreboard monitors: a result is consumed when out_valid && out_ready.
    always @(negedge clk) begin
        if (!rst && if32.out_valid && if32.out_ready) begin
            if (exp_q32.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out32: got result %h, expected no output", if32.result);
            end else begin
                chk("result32", if32.result, exp_q32.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if8.out_valid && if8.out_ready) begin
            if (exp_q8.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out8: got result %h, expected no output", if8.result);
            end else begin
                chk("result8", {48'b0, if8.result}, {48'b0, exp_q8.pop_front()});
            end
        end
    end

    // Directed checks and 32-bit random traffic.
    initial begin
        int j;
        logic [31:0] ra, rb;
        logic rs;
        if32.in_valid = 1'b0;
        if32.a = '0;
        if32.b = '0;
        if32.is_signed = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", if32.out_valid, 0);
        chk("rst_result", if32.result, 0);
        chk("rst_busy", if32.busy, 0);
        chk("rst_in_ready", if32.in_ready, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_idle", if32.in_ready, 1);
        @(posedge clk);
        #1;

        // Latency
        send32(32'd4, 32'd25, 1'b0, 64'd100);
        chk("busy_calc", if32.busy, 1);
        wait_valid32(j);
        chk("latency", j, 17);
        @(posedge clk);
        #1;

        // Back-to-back; second operands are presented while the first is in CALC
        send32(32'd2394324, 32'd394, 1'b0, 64'd943363656);
        send32(32'd3394, 32'd4925, 1'b0, 64'd16715450);
        send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1);
        send32(32'hFFFF_FFF9, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        send32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        send32(32'd0, 32'hFFFF_FFFF, 1'b1, 64'h0);
        wait_valid32(j);
        chk("latency_zero", j, 17);
        @(posedge clk);
        #1;

        // Backpressure stall
        rdy_dir32 = 1'b0;
        send32(32'hFFFF_FC18, 32'd1000, 1'b1, 64'hFFFF_FFFF_FFF0_BDC0);
        wait_valid32(j);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", if32.out_valid, 1);
            chk("stall_in_ready", if32.in_ready, 0);
            chk("stall_result", if32.result, 64'hFFFF_FFFF_FFF0_BDC0);
            @(posedge clk);
            #1;
        end
        rdy_dir32 = 1'b1;
        @(posedge clk);
        #1;
        chk("drop_valid", if32.out_valid, 0);
        chk("idle_busy", if32.busy, 0);

        // Reset mid-CALC: the in-flight product is discarded
        send32(32'd77, 32'd99, 1'b0, 64'd7623);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        void'(exp_q32.pop_back());
        chk("abort_out_valid", if32.out_valid, 0);
        chk("abort_result", if32.result, 0);
        chk("abort_busy", if32.busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_in_ready", if32.in_ready, 1);
        send32(32'd12345, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_9F8E);
        wait_valid32(j);
        chk("latency_after_abort", j, 17);
        @(posedge clk);
        #1;

        // Random traffic with gaps and random backpressure
        rr_en32 = 1'b1;
        start8 = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            ra = pick32();
            rb = pick32();
            rs = $urandom_range(0, 1);
            send32(ra, rb, rs, model32(ra, rb, rs));
        end
        done32 = 1'b1;
    end

    // 8-bit instance: all corner pairs in both modes, then random operands
    initial begin
        if8.in_valid = 1'b0;
        if8.a = '0;
        if8.b = '0;
        if8.is_signed = 1'b0;
        wait (start8);
        rr_en8 = 1'b1;
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 8; i++)
                for (int k = 0; k < 8; k++)
                    send8(corner8[i], corner8[k], s[0]);
        for (int n = 0; n < 1200; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        done8 = 1'b1;
    end

    initial begin
        int n;
        wait (done32 && done8);
        n = 0;
        while ((exp_q32.size() != 0 || exp_q8.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain32", exp_q32.size(), 0);
        chk("drain8", exp_q8.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        fails++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end
endmodule
